// File: rtl/regfile_mp.sv
// ============================================================================
// regfile_mp
// ----------------------------------------------------------------------------
// Parametrised multi-port integer register file.
//   - NUM_RD combinational read ports with write-through forwarding
//   - two write ports; A has priority over B on an address collision
//   - per-register pending-write scoreboard (busy bits)
//   - sequential zero-clear sweep after reset or on clr_req_i
//
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   rd_addr_i      NUM_RD packed read addresses (port k at [k*ADDR_W +: ADDR_W])
//   rd_data_o      NUM_RD packed read data      (port k at [k*DATA_W +: DATA_W])
//   rd_busy_o      per read port: addressed register has an outstanding write
//   wa_*           write port A (high priority, EX path)
//   wb_*           write port B (low priority, load/WB path)
//   alloc_en_i     mark alloc_addr_i as pending-write
//   alloc_addr_i   register to mark busy
//   clr_req_i      start a zero-clear sweep (ignored while one is running)
//   ready_o        1 = file usable, 0 while the sweep runs
// ============================================================================
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     wa_en_i,
    input  logic [ADDR_W-1:0]        wa_addr_i,
    input  logic [DATA_W-1:0]        wa_data_i,
    input  logic                     wb_en_i,
    input  logic [ADDR_W-1:0]        wb_addr_i,
    input  logic [DATA_W-1:0]        wb_data_i,
    input  logic                     alloc_en_i,
    input  logic [ADDR_W-1:0]        alloc_addr_i,
    input  logic                     clr_req_i,
    output logic                     ready_o
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [DATA_W-1:0]   mem [NUM_REGS];

    logic run;
    logic wa_ok;
    logic wb_ok;

    assign run = (state == RUN);

    // Effective writes: only in RUN, never to a hardwired x0, and B is
    // dropped when A hits the same register in the same cycle.
    assign wa_ok = run && wa_en_i && !(ZERO_REG != 0 && wa_addr_i == '0);
    assign wb_ok = run && wb_en_i && !(ZERO_REG != 0 && wb_addr_i == '0)
                   && !(wa_ok && wa_addr_i == wb_addr_i);

    // Sweep/run controller. The sweep counter walks every entry once;
    // leaving INIT happens on the edge that writes the last entry, so
    // ready_o (registered) rises right after the final sweep write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= INIT;
            cnt     <= '0;
            busy    <= '0;
            ready_o <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    cnt  <= cnt + 1'b1;
                    busy <= '0;
                    if (cnt == ADDR_W'(NUM_REGS - 1)) begin
                        state   <= RUN;
                        ready_o <= 1'b1;
                    end
                end
                RUN: begin
                    if (clr_req_i) begin
                        state   <= INIT;
                        cnt     <= '0;
                        busy    <= '0;
                        ready_o <= 1'b0;
                    end else begin
                        busy <= busy_nxt;
                    end
                end
                default: begin
                    state   <= INIT;
                    cnt     <= '0;
                    busy    <= '0;
                    ready_o <= 1'b0;
                end
            endcase
        end
    end

    // Data array has no reset; the sweep is what zeroes it. Port A is
    // written last so it wins even if the collision guard were absent.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[cnt] <= '0;
        end else begin
            if (wb_ok) begin
                mem[wb_addr_i] <= wb_data_i;
            end
            if (wa_ok) begin
                mem[wa_addr_i] <= wa_data_i;
            end
        end
    end

    // Scoreboard update: a new allocation outranks a completing write to
    // the same register, because the allocating instruction is younger.
    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (alloc_en_i && alloc_addr_i == ADDR_W'(i)) begin
                busy_nxt[i] = 1'b1;
            end else if ((wa_en_i && wa_addr_i == ADDR_W'(i)) ||
                         (wb_en_i && wb_addr_i == ADDR_W'(i))) begin
                busy_nxt[i] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            busy_nxt[0] = 1'b0;
        end
    end

    // Read ports with same-cycle forwarding from both write ports. A value
    // being forwarded this cycle is by definition not pending, so busy is
    // masked whenever a write port hits the read address.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              bsy;
        logic              wr_hit;

        assign addr   = rd_addr_i[k*ADDR_W +: ADDR_W];
        assign wr_hit = (wa_en_i && addr == wa_addr_i) ||
                        (wb_en_i && addr == wb_addr_i);

        always_comb begin
            data = '0;
            bsy  = 1'b0;
            if (run && !(ZERO_REG != 0 && addr == '0)) begin
                if (wa_en_i && addr == wa_addr_i) begin
                    data = wa_data_i;
                end else if (wb_en_i && addr == wb_addr_i) begin
                    data = wb_data_i;
                end else begin
                    data = mem[addr];
                end
                bsy = busy[addr] && !wr_hit;
            end
        end

        assign rd_data_o[k*DATA_W +: DATA_W] = data;
        assign rd_busy_o[k]                  = bsy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// ============================================================================
// tb_regfile_mp
// ----------------------------------------------------------------------------
// Self-checking bench for regfile_mp (default parameters: 32 x 32-bit,
// 2 read ports, x0 hardwired). A table of single-cycle vectors covers
// forwarding, write priority, x0 handling and the scoreboard; hand-written
// sequences cover the reset sweep, clear request and reset mid-sweep.
// ============================================================================
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr_i;
    logic [63:0] rd_data_o;
    logic [1:0]  rd_busy_o;
    logic        wa_en_i;
    logic [4:0]  wa_addr_i;
    logic [31:0] wa_data_i;
    logic        wb_en_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        alloc_en_i;
    logic [4:0]  alloc_addr_i;
    logic        clr_req_i;
    logic        ready_o;

    int checks = 0;
    int errors = 0;

    regfile_mp #(
        .DATA_W  (32),
        .ADDR_W  (5),
        .NUM_RD  (2),
        .ZERO_REG(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_addr_i   (rd_addr_i),
        .rd_data_o   (rd_data_o),
        .rd_busy_o   (rd_busy_o),
        .wa_en_i     (wa_en_i),
        .wa_addr_i   (wa_addr_i),
        .wa_data_i   (wa_data_i),
        .wb_en_i     (wb_en_i),
        .wb_addr_i   (wb_addr_i),
        .wb_data_i   (wb_data_i),
        .alloc_en_i  (alloc_en_i),
        .alloc_addr_i(alloc_addr_i),
        .clr_req_i   (clr_req_i),
        .ready_o     (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        wae;
        logic [4:0]  waa;
        logic [31:0] wad;
        logic        wbe;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic        ale;
        logic [4:0]  ala;
        logic [31:0] ex0;
        logic [31:0] ex1;
        logic [1:0]  exb;
    } vec_t;

    vec_t vecs [19];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic idleInputs();
        wa_en_i      = 1'b0;
        wa_addr_i    = '0;
        wa_data_i    = '0;
        wb_en_i      = 1'b0;
        wb_addr_i    = '0;
        wb_data_i    = '0;
        alloc_en_i   = 1'b0;
        alloc_addr_i = '0;
        clr_req_i    = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        rd_addr_i    = {v.ra1, v.ra0};
        wa_en_i      = v.wae;
        wa_addr_i    = v.waa;
        wa_data_i    = v.wad;
        wb_en_i      = v.wbe;
        wb_addr_i    = v.wba;
        wb_data_i    = v.wbd;
        alloc_en_i   = v.ale;
        alloc_addr_i = v.ala;
    endtask

    // Counts sampled cycles with ready_o low, starting from the current
    // (already low) cycle; bounded so a stuck sweep still ends the test.
    task automatic countLow(output int n);
        n = 0;
        while (!ready_o && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic readCheck(input string name, input logic [4:0] a0,
                             input logic [4:0] a1, input logic [31:0] e0,
                             input logic [31:0] e1);
        rd_addr_i = {a1, a0};
        #1;
        checkOutput({name, "_rd0"}, rd_data_o[31:0], e0);
        checkOutput({name, "_rd1"}, rd_data_o[63:32], e1);
        checkOutput({name, "_busy"}, {30'd0, rd_busy_o}, 32'd0);
    endtask

    initial begin
        int n;

        //            ra0 ra1 wae waa wad           wbe wba wbd           ale ala ex0           ex1           exb
        vecs[0]  = '{5,  31, 0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  32'h0,        32'h0,        2'b00};
        vecs[1]  = '{5,  7,  1, 5,  32'hDEADBEEF, 0, 0,  32'h0,        0, 0,  32'hDEADBEEF, 32'h0,        2'b00};
        vecs[2]  = '{5,  5,  0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
        vecs[3]  = '{7,  4,  1, 7,  32'h11111111, 1, 7,  32'h22222222, 0, 0,  32'h11111111, 32'h0,        2'b00};
        vecs[4]  = '{7,  5,  0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  32'h11111111, 32'hDEADBEEF, 2'b00};
        vecs[5]  = '{9,  7,  0, 0,  32'h0,        0, 0,  32'h0,        1, 9,  32'h0,        32'h11111111, 2'b00};
        vecs[6]  = '{9,  9,  0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  32'h0,        32'h0,        2'b11};
        vecs[7]  = '{9,  7,  0, 0,  32'h0,        1, 9,  32'h42,       0, 0,  32'h42,       32'h11111111, 2'b00};
        vecs[8]  = '{9,  9,  0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  32'h42,       32'h42,       2'b00};
        vecs[9]  = '{0,  0,  1, 0,  32'hFFFFFFFF, 0, 0,  32'h0,        1, 0,  32'h0,        32'h0,        2'b00};
        vecs[10] = '{0,  31, 0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  32'h0,        32'h0,        2'b00};
        vecs[11] = '{12, 5,  1, 12, 32'hAA,       0, 0,  32'h0,        1, 12, 32'hAA,       32'hDEADBEEF, 2'b00};
        vecs[12] = '{12, 0,  0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  32'hAA,       32'h0,        2'b01};
        vecs[13] = '{12, 13, 1, 13, 32'hCC,       1, 12, 32'hBB,       0, 0,  32'hBB,       32'hCC,       2'b00};
        vecs[14] = '{12, 13, 0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  32'hBB,       32'hCC,       2'b00};
        vecs[15] = '{3,  12, 1, 3,  32'h5,        0, 0,  32'h0,        0, 0,  32'h5,        32'hBB,       2'b00};
        vecs[16] = '{3,  12, 0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  32'h5,        32'hBB,       2'b00};
        vecs[17] = '{20, 3,  0, 0,  32'h0,        0, 0,  32'h0,        1, 20, 32'h0,        32'h5,        2'b00};
        vecs[18] = '{3,  20, 0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  32'h5,        32'h0,        2'b10};

        // Reset and the power-up sweep.
        idleInputs();
        rd_addr_i = {5'd6, 5'd5};
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_ready", {31'd0, ready_o}, 32'd0);
        checkOutput("reset_busy", {30'd0, rd_busy_o}, 32'd0);
        checkOutput("reset_rd0", rd_data_o[31:0], 32'd0);
        rst = 1'b0;
        countLow(n);
        checkOutput("sweep_low_cycles", n, 32'd32);
        checkOutput("sweep_ready_high", {31'd0, ready_o}, 32'd1);
        readCheck("post_sweep_a", 5'd0, 5'd31, 32'd0, 32'd0);
        readCheck("post_sweep_b", 5'd5, 5'd17, 32'd0, 32'd0);

        // Table-driven single-cycle vectors in RUN.
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d_rd0", i), rd_data_o[31:0], vecs[i].ex0);
            checkOutput($sformatf("vec%0d_rd1", i), rd_data_o[63:32], vecs[i].ex1);
            checkOutput($sformatf("vec%0d_busy", i), {30'd0, rd_busy_o}, {30'd0, vecs[i].exb});
        end

        // Clear request: x3 holds 5 and x20 is busy beforehand.
        @(negedge clk);
        idleInputs();
        rd_addr_i = {5'd20, 5'd3};
        clr_req_i = 1'b1;
        @(negedge clk);
        clr_req_i    = 1'b0;
        wa_en_i      = 1'b1;
        wa_addr_i    = 5'd3;
        wa_data_i    = 32'h99;
        alloc_en_i   = 1'b1;
        alloc_addr_i = 5'd21;
        rd_addr_i    = {5'd21, 5'd3};
        #1;
        checkOutput("init_fwd_blocked", rd_data_o[31:0], 32'd0);
        checkOutput("init_busy", {30'd0, rd_busy_o}, 32'd0);
        countLow(n);
        idleInputs();
        checkOutput("clr_low_cycles", n, 32'd32);
        readCheck("post_clr_a", 5'd3, 5'd20, 32'd0, 32'd0);
        readCheck("post_clr_b", 5'd21, 5'd5, 32'd0, 32'd0);

        // Reset ten cycles into a sweep restarts it from entry 0.
        @(negedge clk);
        wa_en_i   = 1'b1;
        wa_addr_i = 5'd30;
        wa_data_i = 32'h77;
        @(negedge clk);
        idleInputs();
        clr_req_i = 1'b1;
        @(negedge clk);
        clr_req_i = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midsweep_rst_ready", {31'd0, ready_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        countLow(n);
        checkOutput("midsweep_low_cycles", n, 32'd32);
        readCheck("post_rst_sweep", 5'd30, 5'd7, 32'd0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the current 2-read/1-write file.
- Adds configurable width, depth and read-port count, and two write ports with fixed priority.
- Adds a per-register pending-write scoreboard and a sequential zero-initialisation sweep after reset or on request.
- Sits between ID (reads, scoreboard allocation) and EX/WB (write-back).

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register address width; depth NUM_REGS = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr_i  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data_o  out  NUM_RD*DATA_W  read data, combinational; port k uses bits [k*DATA_W +: DATA_W].
- rd_busy_o  out  NUM_RD  1 = addressed register has an outstanding allocated write.
- wa_en_i  in  1  write port A enable (high priority, EX path).
- wa_addr_i  in  ADDR_W  write port A address.
- wa_data_i  in  DATA_W  write port A data.
- wb_en_i  in  1  write port B enable (low priority, load/WB path).
- wb_addr_i  in  ADDR_W  write port B address.
- wb_data_i  in  DATA_W  write port B data.
- alloc_en_i  in  1  mark alloc_addr_i as pending-write (issue of a writing instruction).
- alloc_addr_i  in  ADDR_W  register to mark busy.
- clr_req_i  in  1  pulse: start a zero-clear sweep (ignored while a sweep is running).
- ready_o  out  1  1 = file usable; 0 during sweep.

Behaviour:
- States: INIT (sweep) and RUN. rst asserted: state <= INIT, sweep counter <= 0, all busy bits <= 0, ready_o = 0, asynchronously. The data array is not reset.
- INIT:
  - Each cycle writes 0 to entry cnt and increments cnt.
  - After the cycle writing entry NUM_REGS-1, go to RUN; ready_o is high on the next cycle.
  - Sweep takes exactly NUM_REGS cycles.
- INIT side effects:
  - All reads return 0 and rd_busy_o = 0.
  - wa/wb/alloc are ignored; busy bits are held at 0.
- RUN: clr_req_i = 1 -> INIT next cycle with cnt = 0; busy bits cleared on the same edge.
- Reset mid-sweep restarts the sweep from entry 0.
- Writes (RUN):
  - Registered on the rising edge.
  - If both ports target the same address, A's data is stored and B is dropped.
  - Writes to address 0 are discarded when ZERO_REG = 1.
- Reads (RUN), combinational, per port, in priority order:
  1. Address 0 with ZERO_REG -> 0.
  2. wa_en_i and address == wa_addr_i -> wa_data_i.
  3. wb_en_i and address == wb_addr_i -> wb_data_i.
  4. Otherwise -> array content.
- Scoreboard (RUN), per register, next busy bit:
  - Set if alloc_en_i targets it.
  - Else cleared if any write port targets it.
  - Else held.
  - Alloc and write to the same register in one cycle: data is written and busy stays/becomes 1 (newer producer wins).
  - Register 0 is never set busy when ZERO_REG = 1.
- rd_busy_o[k] = busy[addr_k] AND NOT (a write to addr_k this cycle), so a forwarded value is never flagged busy. It is 0 for address 0 with ZERO_REG.
- No latency beyond one edge for writes; reads have zero latency.

Test Plan:
- Reset, then hold idle -> ready_o = 0 for exactly 32 cycles, rises on cycle 33; all reads return 0x0 after the sweep.
- RUN, wa writes x5 = 0xDEADBEEF while rd port 0 reads x5 in the same cycle -> rd_data_o[0] = 0xDEADBEEF that cycle and every later cycle.
- Same cycle: wa x7 = 0x11111111 and wb x7 = 0x22222222; next cycle read x7 -> 0x11111111.
- alloc x9; next cycle read x9 -> rd_busy_o = 1; wb writes x9 = 0x42 -> busy 0 that cycle and after; data = 0x42.
- wa writes x0 = 0xFFFFFFFF and alloc x0 -> read x0 = 0, rd_busy_o = 0.
- After writing x3 = 0x5, pulse clr_req_i -> ready_o low 32 cycles; x3 reads 0 afterwards.
- Assert rst at cycle 10 of a sweep -> the sweep restarts and ready_o rises 32 cycles after rst deassertion.
